// File: rtl/arb_gnt_capture_fifo.sv
// Purpose : captures the arbiter's winning client payload and source index into a FIFO.
// Latency : a grant seen at edge N is written at edge N+1; out_valid follows that edge (no bypass).
// Backpressure: o_req_stall asserts at fill >= DEPTH-AFULL_MARGIN; a grant arriving while full
//               without a pop is dropped and flags o_overflow.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_gnt [CLIENTS]           registered one-hot (or zero) grant from the arbiter
//   i_client_data             client i payload at [i*DATA_W +: DATA_W]
//   o_req_stall               request side must stop requesting
//   o_out_valid/i_out_ready   head handshake; o_out_data / o_out_src give the head entry
//   o_fill                    occupancy 0..DEPTH
//   o_overflow                sticky: grant arrived while full with no pop
//   o_err_multi_gnt           sticky: multi-hot grant seen (only when GNT_CHECK_EN is defined)
//
// Optional feature macro: GNT_CHECK_EN (one-hot check, lowest-index winner on multi-hot).
module arb_gnt_capture_fifo #(
  parameter  int CLIENTS      = 16,
  parameter  int DATA_W       = 32,
  parameter  int DEPTH        = 8,
  parameter  int AFULL_MARGIN = 2,
  localparam int SRC_W        = $clog2(CLIENTS),
  localparam int PTR_W        = $clog2(DEPTH),
  localparam int FILL_W       = PTR_W + 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [CLIENTS-1:0]          i_gnt,
  input  logic [CLIENTS*DATA_W-1:0]   i_client_data,
  output logic                        o_req_stall,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [DATA_W-1:0]           o_out_data,
  output logic [SRC_W-1:0]            o_out_src,
  output logic [FILL_W-1:0]           o_fill,
  output logic                        o_overflow,
  output logic                        o_err_multi_gnt
);

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] dat;
  } entry_t;

  // Occupancy state is fully encoded by r_fill; the enum is a decoded view of it.
  typedef enum logic [1:0] {
    OCC_EMPTY  = 2'd0,
    OCC_ACTIVE = 2'd1,
    OCC_STALL  = 2'd2
  } occ_e;

  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_STALL = FILL_W'(DEPTH - AFULL_MARGIN);

  entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] w_fill_nxt;
  logic              r_overflow;
  occ_e              w_occ;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_wr_en;
  logic [SRC_W-1:0]  w_sel_src;
  logic [DATA_W-1:0] w_sel_dat;

  // ---------------------------------------------------------------------------
  // Grant decode: pick source index and payload for the entry to be written.
  // ---------------------------------------------------------------------------
`ifdef GNT_CHECK_EN
  logic w_multi;
  logic r_err_multi;

  // x & (x-1) clears the lowest set bit; anything left means more than one bit.
  assign w_multi = |(i_gnt & (i_gnt - CLIENTS'(1)));

  // Scan from the top so the lowest-index set bit is the last to assign.
  always_comb begin
    w_sel_src = '0;
    w_sel_dat = '0;
    for (int i = CLIENTS - 1; i >= 0; i--) begin
      if (i_gnt[i]) begin
        w_sel_src = SRC_W'(i);
        w_sel_dat = i_client_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_multi <= 1'b0;
    end else if (w_push && w_multi) begin
      r_err_multi <= 1'b1;
    end
  end

  assign o_err_multi_gnt = r_err_multi;
`else
  // AND-OR mux: correct for one-hot, merged garbage for multi-hot.
  always_comb begin
    w_sel_src = '0;
    w_sel_dat = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      if (i_gnt[i]) begin
        w_sel_src = w_sel_src | SRC_W'(i);
        w_sel_dat = w_sel_dat | i_client_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign o_err_multi_gnt = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Push / pop qualification
  // ---------------------------------------------------------------------------
  assign w_push  = |i_gnt;
  assign w_pop   = o_out_valid && i_out_ready;
  assign w_full  = (r_fill == FILL_FULL);
  // When full, a simultaneous pop frees the slot being written this same edge.
  assign w_wr_en = w_push && (!w_full || w_pop);

  // Storage is intentionally not reset; validity is tracked by r_fill alone.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= '{src: w_sel_src, dat: w_sel_dat};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy state machine: r_fill is the state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fill <= '0;
    end else begin
      r_fill <= w_fill_nxt;
    end
  end

  always_comb begin
    w_fill_nxt = r_fill;
    w_occ      = OCC_ACTIVE;
    if (w_wr_en && !w_pop) begin
      w_fill_nxt = r_fill + FILL_W'(1);
    end else if (w_pop && !w_wr_en) begin
      w_fill_nxt = r_fill - FILL_W'(1);
    end
    if (r_fill == '0) begin
      w_occ = OCC_EMPTY;
    end else if (r_fill >= FILL_STALL) begin
      w_occ = OCC_STALL;
    end
  end

  // Decoded purely from registered fill, so gnt activity cannot glitch it.
  assign o_req_stall = (w_occ == OCC_STALL);
  assign o_out_valid = (w_occ != OCC_EMPTY);
  assign o_fill      = r_fill;
  assign o_overflow  = r_overflow;
  assign o_out_data  = r_mem[r_rd_ptr].dat;
  assign o_out_src   = r_mem[r_rd_ptr].src;

endmodule

// File: tb/tb_arb_gnt_capture_fifo.sv
// Purpose : directed scoreboard bench for arb_gnt_capture_fifo (CLIENTS=16, DATA_W=32, DEPTH=8, MARGIN=2).
// Latency : stimulus applied 1ns after a rising edge; monitor compares popped heads on the falling edge.
// Backpressure: honours req_stall in the wrap sequence; other sequences drive grants into a full FIFO deliberately.
module tb_arb_gnt_capture_fifo;

  localparam int CLIENTS = 16;
  localparam int DATA_W  = 32;

  typedef struct packed {
    logic [3:0]  src;
    logic [31:0] dat;
  } exp_t;

  logic                      clk;
  logic                      rst_n;
  logic [CLIENTS-1:0]        gnt;
  logic [CLIENTS*DATA_W-1:0] client_data;
  logic                      req_stall;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [3:0]                out_src;
  logic [3:0]                fill;
  logic                      overflow;
  logic                      err_multi_gnt;

  exp_t q[$];
  int   m_fill;
  int   n_vec;
  int   n_err;

  arb_gnt_capture_fifo dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_gnt          (gnt),
    .i_client_data  (client_data),
    .o_req_stall    (req_stall),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_out_data     (out_data),
    .o_out_src      (out_src),
    .o_fill         (fill),
    .o_overflow     (overflow),
    .o_err_multi_gnt(err_multi_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_unexpected: got src %0d data %0h expected no entry", out_src, out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pop_src", 64'(out_src), 64'(e.src));
        chk("pop_data", 64'(out_data), 64'(e.dat));
      end
    end
  end

  function automatic int lowest(input logic [CLIENTS-1:0] g);
    for (int i = 0; i < CLIENTS; i++) begin
      if (g[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [31:0] slice(input int c);
    logic [CLIENTS*DATA_W-1:0] v;
    v = client_data;
    return v[c*DATA_W +: DATA_W];
  endfunction

  task automatic set_client(input int c, input logic [31:0] d);
    client_data[c*DATA_W +: DATA_W] = d;
  endtask

  task automatic default_data();
    for (int c = 0; c < CLIENTS; c++) set_client(c, 32'hA5A5_0000 | 32'(c));
  endtask

  // Called at posedge+1: drives one cycle of inputs, records the expected entry
  // if the FIFO can take it, then returns at posedge+1 after the edge that applied it.
  task automatic step(input logic [CLIENTS-1:0] g, input logic rdy);
    bit pop;
    bit acc;
    exp_t e;
    gnt       = g;
    out_ready = rdy;
    pop = (m_fill != 0) && rdy;
    acc = (g != '0) && ((m_fill < 8) || pop);
    if (acc) begin
      e.src = 4'(lowest(g));
      e.dat = slice(lowest(g));
      q.push_back(e);
      m_fill++;
    end
    if (pop) m_fill--;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int seq;
    int cycles;
    bit rdy;
    n_vec = 0;
    n_err = 0;
    m_fill = 0;
    gnt = '0;
    out_ready = 1'b0;
    default_data();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_stall", 64'(req_stall), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_err_multi", 64'(err_multi_gnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single grant to client 3, then popped.
    step(16'h0008, 1'b1);
    chk("single_fill", 64'(fill), 64'd1);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", 64'(out_data), 64'hA5A5_0003);
    chk("single_src", 64'(out_src), 64'd3);
    step(16'h0000, 1'b1);
    chk("single_drained", 64'(fill), 64'd0);
    chk("single_valid_lo", 64'(out_valid), 64'd0);

    // Fill to stall threshold and then to full.
    for (int k = 0; k < 8; k++) begin
      step(16'(1 << k), 1'b0);
      chk("fill_cnt", 64'(fill), 64'(k + 1));
      chk("fill_stall", 64'(req_stall), (k + 1 >= 6) ? 64'd1 : 64'd0);
    end
    chk("full_overflow", 64'(overflow), 64'd0);

    // Full with simultaneous push and pop: both accepted.
    step(16'h8000, 1'b1);
    chk("pp_fill", 64'(fill), 64'd8);
    chk("pp_overflow", 64'(overflow), 64'd0);
    chk("pp_head_src", 64'(out_src), 64'd1);

    // Full with no pop: grant dropped, head unchanged.
    step(16'h0001, 1'b0);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_fill", 64'(fill), 64'd8);
    chk("ovf_head_src", 64'(out_src), 64'd1);
    chk("ovf_head_data", 64'(out_data), 64'hA5A5_0001);
    for (int k = 0; k < 8; k++) step(16'h0000, 1'b1);
    chk("drain_fill", 64'(fill), 64'd0);

    // Wrap: 20 grants, ready toggling, grants held back while stalled.
    seq = 0;
    cycles = 0;
    rdy = 1'b1;
    while (seq < 20 && cycles < 200) begin
      if (!req_stall) begin
        set_client(seq % 16, 32'hC0DE_0000 | 32'(seq << 8) | 32'(seq % 16));
        step(16'(1 << (seq % 16)), rdy);
        seq++;
      end else begin
        step(16'h0000, rdy);
      end
      rdy = !rdy;
      cycles++;
    end
    chk("wrap_issued", 64'(seq), 64'd20);
    while (m_fill != 0 && cycles < 300) begin
      step(16'h0000, 1'b1);
      cycles++;
    end
    chk("wrap_fill", 64'(fill), 64'd0);
    chk("wrap_queue_empty", 64'(q.size()), 64'd0);
    default_data();

    // Reset mid-stream at fill=5.
    for (int k = 8; k < 13; k++) step(16'(1 << k), 1'b0);
    chk("pre_rst_fill", 64'(fill), 64'd5);
    chk("pre_rst_stall", 64'(req_stall), 64'd0);
    rst_n = 1'b0;
    gnt = 16'h0004;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_fill", 64'(fill), 64'd0);
    chk("mid_rst_stall", 64'(req_stall), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    q.delete();
    m_fill = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    gnt = '0;
    @(posedge clk);
    #1;
    chk("post_rst_fill", 64'(fill), 64'd0);
    step(16'h0010, 1'b0);
    chk("post_rst_src", 64'(out_src), 64'd4);
    chk("post_rst_data", 64'(out_data), 64'hA5A5_0004);
    step(16'h0000, 1'b1);
    chk("post_rst_drain", 64'(fill), 64'd0);

`ifdef GNT_CHECK_EN
    step(16'h0102, 1'b0);
    chk("multi_err", 64'(err_multi_gnt), 64'd1);
    chk("multi_src", 64'(out_src), 64'd1);
    chk("multi_fill", 64'(fill), 64'd1);
    step(16'h0000, 1'b1);
`else
    chk("multi_err_tied", 64'(err_multi_gnt), 64'd0);
`endif

    step(16'h0000, 1'b0);
    chk("end_queue_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
